// File: rtl/ram_access_ctrl.sv
// Arbitrates instruction-fetch and data requests onto a strobe-driven RAM,
// sequencing enable/ready handshakes, dword split transfers and WAIT timeouts.
module ram_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_dtype,
    input  logic [7:0]  d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        mem_enable,
    output logic        mem_ready,
    output logic        mem_rw,
    output logic [1:0]  mem_dtype,
    output logic        mem_dwp1,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_clear,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);
    localparam int unsigned CW       = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  DT_WORD  = 2'b10;
    localparam logic [1:0]  DT_DWORD = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, RELEASE, ACK} state_t;

    state_t        state;
    logic          last_d;
    logic          gnt_d;
    logic          phase2;
    logic          aborted;
    logic [1:0]    dtype;
    logic [31:0]   wd_lo;
    logic [31:0]   hi_buf;
    logic [CW-1:0] wait_cnt;

    logic          grant_d;
    logic          sel_rw;
    logic [1:0]    sel_dtype;
    logic [7:0]    sel_addr;
    logic [63:0]   sel_wdata;
    logic          is_dword;

    function automatic logic [7:0] align_addr(input logic [7:0] a, input logic [1:0] t);
        case (t)
            2'b01:   return a & 8'hFE;
            2'b10:   return a & 8'hFC;
            2'b11:   return a & 8'hF8;
            default: return a;
        endcase
    endfunction

    // Round-robin choice: data wins unless fetch is also pending and data won last.
    always_comb begin
        grant_d   = d_req && (!if_req || !last_d);
        sel_rw    = 1'b0;
        sel_dtype = DT_WORD;
        sel_addr  = if_addr;
        sel_wdata = '0;
        if (grant_d) begin
            sel_rw    = d_rw;
            sel_dtype = d_dtype;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
    end

    assign is_dword = (dtype == DT_DWORD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_d      <= 1'b0;
            gnt_d       <= 1'b0;
            phase2      <= 1'b0;
            aborted     <= 1'b0;
            dtype       <= '0;
            wd_lo       <= '0;
            hi_buf      <= '0;
            wait_cnt    <= '0;
            mem_enable  <= 1'b1;
            mem_ready   <= 1'b0;
            mem_rw      <= 1'b0;
            mem_dtype   <= '0;
            mem_dwp1    <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_ack      <= 1'b0;
            d_ack       <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if_ack      <= 1'b0;
            d_ack       <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        gnt_d      <= grant_d;
                        last_d     <= grant_d;
                        dtype      <= sel_dtype;
                        wd_lo      <= sel_wdata[31:0];
                        phase2     <= 1'b0;
                        aborted    <= 1'b0;
                        hi_buf     <= '0;
                        mem_addr   <= align_addr(sel_addr, sel_dtype);
                        mem_rw     <= sel_rw;
                        mem_dtype  <= sel_dtype;
                        mem_dwp1   <= 1'b1;
                        mem_wdata  <= (sel_dtype == DT_DWORD) ? sel_wdata[63:32] : sel_wdata[31:0];
                        mem_enable <= 1'b0;
                        mem_ready  <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    mem_enable <= 1'b0;
                    mem_ready  <= 1'b1;
                    state      <= STROBE;
                end
                STROBE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (mem_clear) begin
                        mem_enable <= 1'b1;
                        state      <= RELEASE;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        aborted    <= 1'b1;
                        mem_enable <= 1'b1;
                        state      <= RELEASE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    // Ready falls while enable is still high, so the RAM ignores this edge;
                    // enable then stays high through the dword phase-2 SETUP for the same reason.
                    mem_ready <= 1'b0;
                    if (is_dword && !phase2 && !aborted) begin
                        hi_buf    <= mem_rdata;
                        phase2    <= 1'b1;
                        mem_dwp1  <= 1'b0;
                        mem_wdata <= wd_lo;
                        state     <= SETUP;
                    end else begin
                        timeout_err <= aborted;
                        state       <= ACK;
                        if (gnt_d) begin
                            d_ack <= 1'b1;
                            if (aborted)
                                d_rdata <= '0;
                            else if (is_dword)
                                d_rdata <= {hi_buf, mem_rdata};
                            else
                                d_rdata <= {32'h0, mem_rdata};
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= aborted ? 32'h0 : mem_rdata;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: a byte-array RAM responder plus a
// reference memory predicting every RAM operation and every ack payload.
module tb_ram_access_ctrl;
    localparam int unsigned TMO = 16;

    logic        clk;
    logic        reset;
    logic        if_req, if_ack;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_rw, d_ack;
    logic [1:0]  d_dtype;
    logic [7:0]  d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic        mem_enable, mem_ready, mem_rw, mem_dwp1, mem_clear;
    logic [1:0]  mem_dtype;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        timeout_err;

    ram_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_dtype(d_dtype), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_enable(mem_enable), .mem_ready(mem_ready), .mem_rw(mem_rw),
        .mem_dtype(mem_dtype), .mem_dwp1(mem_dwp1), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_clear(mem_clear), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit is_d; bit chk; bit tmo; logic [63:0] data; } resp_t;
    typedef struct { logic [7:0] addr; logic [1:0] dt; bit rw; bit dwp1; logic [31:0] wd; } op_t;

    resp_t      resp_q[$];
    op_t        op_q[$];
    logic [7:0] init_mem [256];
    logic [7:0] ref_mem  [256];
    logic [7:0] ram_mem  [256];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ram_lat  = 0;
    bit         ram_hang = 0;
    bit         loaded   = 0;
    bit         busy;
    int         cnt;
    logic       ready_q;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endfunction

    function automatic int nbytes(input logic [1:0] dt);
        return 1 << dt;
    endfunction

    function automatic logic [7:0] base_of(input logic [7:0] a, input logic [1:0] dt);
        return a & ~8'(nbytes(dt) - 1);
    endfunction

    // Reference memory: little-endian bytes, one access of the whole size at the aligned address.
    function automatic logic [63:0] ref_read(input logic [1:0] dt, input logic [7:0] a);
        logic [63:0] v = '0;
        logic [7:0]  b = base_of(a, dt);
        for (int i = 0; i < nbytes(dt); i++) v[8*i +: 8] = ref_mem[8'(b + 8'(i))];
        return v;
    endfunction

    function automatic void ref_write(input logic [1:0] dt, input logic [7:0] a, input logic [63:0] wd);
        logic [7:0] b = base_of(a, dt);
        for (int i = 0; i < nbytes(dt); i++) ref_mem[8'(b + 8'(i))] = wd[8*i +: 8];
    endfunction

    function automatic void push_ops(input bit rw, input logic [1:0] dt, input logic [7:0] a, input logic [63:0] wd);
        logic [7:0] b = base_of(a, dt);
        if (dt == 2'b11) begin
            op_q.push_back('{b, dt, rw, 1'b1, wd[63:32]});
            op_q.push_back('{b, dt, rw, 1'b0, wd[31:0]});
        end else begin
            op_q.push_back('{b, dt, rw, 1'b1, wd[31:0]});
        end
    endfunction

    // RAM responder: a dword's first word (dwp1=1) lives at the upper four bytes.
    function automatic logic [31:0] ram_op();
        op_t        e;
        int         n;
        logic [7:0] b;
        logic [31:0] v = '0;
        if (op_q.size() == 0) begin
            note_fail("unexpected_ram_op");
        end else begin
            e = op_q.pop_front();
            chk("mem_addr", 64'(mem_addr), 64'(e.addr));
            chk("mem_dtype", 64'(mem_dtype), 64'(e.dt));
            chk("mem_rw", 64'(mem_rw), 64'(e.rw));
            chk("mem_dwp1", 64'(mem_dwp1), 64'(e.dwp1));
            if (e.rw) chk("mem_wdata", 64'(mem_wdata), 64'(e.wd));
        end
        n = (mem_dtype == 2'b11) ? 4 : nbytes(mem_dtype);
        b = 8'(mem_addr + ((mem_dtype == 2'b11 && mem_dwp1) ? 8'd4 : 8'd0));
        for (int i = 0; i < n; i++) begin
            if (mem_rw) ram_mem[8'(b + 8'(i))] = mem_wdata[8*i +: 8];
            else        v[8*i +: 8] = ram_mem[8'(b + 8'(i))];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        ready_q <= mem_ready;
        if (reset) begin
            mem_clear <= 1'b0;
            mem_rdata <= '0;
            busy      <= 1'b0;
            cnt       <= 0;
            if (!loaded) begin
                for (int i = 0; i < 256; i++) ram_mem[i] = init_mem[i];
                loaded = 1'b1;
            end
        end else if (mem_enable) begin
            mem_clear <= 1'b0;
            busy      <= 1'b0;
        end else if (mem_ready && !ready_q) begin
            mem_rdata <= ram_op();
            busy      <= 1'b1;
            cnt       <= ram_lat;
            if (!ram_hang && ram_lat == 0) mem_clear <= 1'b1;
        end else if (busy && !ram_hang && !mem_clear) begin
            if (cnt <= 1) mem_clear <= 1'b1;
            else          cnt <= cnt - 1;
        end
    end

    // Monitor: pops the expected response whenever an ack appears.
    initial begin
        resp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (if_ack && d_ack) begin
                    note_fail("both_acks_together");
                end else if (if_ack || d_ack) begin
                    if (resp_q.size() == 0) begin
                        note_fail("unexpected_ack");
                    end else begin
                        r = resp_q.pop_front();
                        chk("ack_source_is_data", 64'(d_ack), 64'(r.is_d));
                        if (r.chk) chk("read_data", d_ack ? d_rdata : {32'h0, if_rdata}, r.data);
                        chk("timeout_err_at_ack", 64'(timeout_err), 64'(r.tmo));
                    end
                end else if (timeout_err) begin
                    note_fail("timeout_err_without_ack");
                end
            end
        end
    end

    task automatic wait_ack(input bit is_d, output int c);
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!(is_d ? d_ack : if_ack) && c < 400);
        chk(is_d ? "d_ack_seen" : "if_ack_seen", 64'(is_d ? d_ack : if_ack), 64'd1);
    endtask

    task automatic access(input bit is_d, input bit rw, input logic [1:0] dt, input logic [7:0] a,
                          input logic [63:0] wd, input int exp_lat, input bit tmo);
        resp_t      r;
        int         c;
        logic [1:0] edt = is_d ? dt : 2'b10;
        bit         erw = is_d ? rw : 1'b0;
        push_ops(erw, edt, a, wd);
        r.is_d = is_d;
        r.tmo  = tmo;
        r.chk  = 1'b1;
        r.data = '0;
        if (tmo)      r.data = '0;
        else if (erw) begin r.chk = 1'b0; ref_write(edt, a, wd); end
        else          r.data = ref_read(edt, a);
        resp_q.push_back(r);
        @(posedge clk);
        #1;
        if (is_d) begin
            d_rw = rw; d_dtype = dt; d_addr = a; d_wdata = wd; d_req = 1'b1;
        end else begin
            if_addr = a; if_req = 1'b1;
        end
        wait_ack(is_d, c);
        if (exp_lat > 0) chk("ack_latency", 64'(c), 64'(exp_lat));
        d_req  = 1'b0;
        if_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] dad [3];
        logic [1:0] ddt [3];
        logic [7:0] fad [3];
        int         c;
        bit         bad;
        resp_t      r;

        for (int i = 0; i < 256; i++) begin
            init_mem[i] = 8'($urandom);
            ref_mem[i]  = init_mem[i];
        end
        for (int k = 0; k < 3; k++) begin
            dad[k] = 8'($urandom);
            ddt[k] = 2'($urandom_range(0, 2));
            fad[k] = 8'($urandom);
        end
        reset = 1'b1;
        d_rw = 1'b0; d_dtype = ddt[0]; d_addr = dad[0]; d_wdata = '0; d_req = 1'b1;
        if_addr = fad[0]; if_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_enable", 64'(mem_enable), 64'd1);
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        chk("rst_mem_rw", 64'(mem_rw), 64'd0);
        chk("rst_mem_dtype", 64'(mem_dtype), 64'd0);
        chk("rst_mem_dwp1", 64'(mem_dwp1), 64'd1);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_acks", 64'({if_ack, d_ack, timeout_err}), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);

        // Both requesters pending out of reset: data first, then strict alternation.
        for (int k = 0; k < 3; k++) begin
            push_ops(1'b0, ddt[k], dad[k], '0);
            r = '{1'b1, 1'b1, 1'b0, ref_read(ddt[k], dad[k])};
            resp_q.push_back(r);
            push_ops(1'b0, 2'b10, fad[k], '0);
            r = '{1'b0, 1'b1, 1'b0, ref_read(2'b10, fad[k])};
            resp_q.push_back(r);
        end
        reset = 1'b0;
        fork
            begin
                int cd;
                for (int k = 0; k < 3; k++) begin
                    d_dtype = ddt[k]; d_addr = dad[k]; d_req = 1'b1;
                    wait_ack(1'b1, cd);
                end
                d_req = 1'b0;
            end
            begin
                int cf;
                for (int k = 0; k < 3; k++) begin
                    if_addr = fad[k]; if_req = 1'b1;
                    wait_ack(1'b0, cf);
                end
                if_req = 1'b0;
            end
        join
        @(posedge clk);
        #1;

        ram_lat = 0;
        access(1'b1, 1'b1, 2'b00, 8'h13, 64'hAB, 5, 1'b0);
        access(1'b1, 1'b0, 2'b00, 8'h13, '0, 5, 1'b0);
        chk("byte_read_back", d_rdata, 64'h00000000_000000AB);
        access(1'b1, 1'b1, 2'b10, 8'h42, 64'hDEADBEEF, 5, 1'b0);
        access(1'b0, 1'b0, 2'b10, 8'h41, '0, 5, 1'b0);
        chk("fetch_word", 64'(if_rdata), 64'hDEADBEEF);
        ram_lat = 1;
        access(1'b1, 1'b1, 2'b11, 8'h25, 64'h01234567_89ABCDEF, 11, 1'b0);
        access(1'b1, 1'b0, 2'b11, 8'h20, '0, 11, 1'b0);
        chk("dword_read_back", d_rdata, 64'h01234567_89ABCDEF);

        ram_hang = 1'b1;
        access(1'b1, 1'b0, 2'b10, 8'h88, '0, TMO + 4, 1'b1);
        ram_hang = 1'b0;
        ram_lat  = 0;
        access(1'b1, 1'b0, 2'b01, 8'h43, '0, 5, 1'b0);

        // Reset while the RAM is still busy in WAIT.
        ram_lat = 10;
        push_ops(1'b0, 2'b10, 8'h60, '0);
        @(posedge clk);
        #1;
        d_rw = 1'b0; d_dtype = 2'b10; d_addr = 8'h60; d_req = 1'b1;
        c = 0;
        while (!mem_ready && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("strobe_before_reset", 64'(mem_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        d_req = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_in_wait_enable", 64'(mem_enable), 64'd1);
        chk("reset_in_wait_ready", 64'(mem_ready), 64'd0);
        bad = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (d_ack || if_ack || timeout_err) bad = 1'b1;
        end
        chk("no_ack_after_reset", 64'(bad), 64'd0);
        ram_lat = 0;
        access(1'b1, 1'b0, 2'b10, 8'h60, '0, 5, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] dt = 2'($urandom_range(0, 3));
            bit         rw = 1'($urandom_range(0, 1));
            ram_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0)
                access(1'b0, 1'b0, 2'b10, 8'($urandom), '0, 5 + ram_lat, 1'b0);
            else
                access(1'b1, rw, dt, 8'($urandom), {$urandom, $urandom},
                       5 + ram_lat + ((dt == 2'b11) ? 4 + ram_lat : 0), 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        chk("op_queue_drained", 64'(op_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
